// File: rtl/ds_lifo.sv
// ds_lifo: last-in-first-out stream buffer with registered handshake and level reporting.
// The top of stack falls through to o_rd_data while o_rd_vld is high; CAPACITY=0 is a wire bypass.
module ds_lifo #(
    parameter int unsigned CAPACITY = 8,
    parameter type DTYPE = logic [7:0],
    localparam int unsigned LW = (CAPACITY == 0) ? 1 : $clog2(CAPACITY + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_vld,
    output logic          o_wr_rdy,
    input  DTYPE          i_wr_data,
    output logic          o_rd_vld,
    input  logic          i_rd_rdy,
    output DTYPE          o_rd_data,
    input  logic [LW-1:0] i_wr_lvl_thr,
    output logic          o_wr_lim,
    output logic [LW-1:0] o_wr_lvl,
    output logic          o_wr_lvl_gte,
    input  logic [LW-1:0] i_rd_lvl_thr,
    output logic          o_rd_lim,
    output logic [LW-1:0] o_rd_lvl,
    output logic          o_rd_lvl_gte
);

    generate
        if (CAPACITY == 0) begin : g_bypass
            // Zero-capacity buffer: straight wires, no state, no levels.
            assign o_wr_rdy     = i_rd_rdy;
            assign o_rd_vld     = i_wr_vld;
            assign o_rd_data    = i_wr_data;
            assign o_wr_lim     = 1'b0;
            assign o_wr_lvl     = '0;
            assign o_wr_lvl_gte = 1'b0;
            assign o_rd_lim     = 1'b0;
            assign o_rd_lvl     = '0;
            assign o_rd_lvl_gte = 1'b0;

            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst, i_wr_lvl_thr, i_rd_lvl_thr};
        end else begin : g_stack
            localparam int unsigned AW = (CAPACITY < 2) ? 1 : $clog2(CAPACITY);
            localparam logic [LW-1:0] CAP_L = LW'(CAPACITY);

            DTYPE          r_mem [CAPACITY];
            logic [LW-1:0] r_cnt;
            logic          r_wr_rdy;
            logic          r_rd_vld;
            logic          r_wr_lim;
            logic [LW-1:0] r_wr_lvl;
            logic          r_wr_lvl_gte;
            logic          r_rd_lim;
            logic [LW-1:0] r_rd_lvl;
            logic          r_rd_lvl_gte;

            logic          w_push;
            logic          w_pop;
            logic [LW-1:0] w_nxt;
            logic [LW-1:0] w_free;
            logic [AW-1:0] w_top_addr;
            logic [AW-1:0] w_waddr;

            // Transfer qualifiers and next stack pointer; push and pop together leave it unchanged.
            always_comb begin
                w_push     = i_wr_vld & r_wr_rdy;
                w_pop      = r_rd_vld & i_rd_rdy;
                w_nxt      = r_cnt + LW'(w_push) - LW'(w_pop);
                w_free     = CAP_L - w_nxt;
                w_top_addr = AW'(r_cnt - LW'(1));
                // A simultaneous pop frees the top slot, so the new word overwrites it in place.
                w_waddr    = w_pop ? w_top_addr : AW'(r_cnt);
            end

            // Storage array; contents are never reset, stale entries are ignored via r_cnt.
            always_ff @(posedge i_clk) begin
                if (w_push) begin
                    r_mem[w_waddr] <= i_wr_data;
                end
            end

            // Stack pointer, handshake and levels, all registered from the next count.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_cnt        <= '0;
                    r_wr_rdy     <= 1'b1;
                    r_rd_vld     <= 1'b0;
                    r_wr_lim     <= 1'b0;
                    r_wr_lvl     <= CAP_L;
                    r_wr_lvl_gte <= 1'b1;
                    r_rd_lim     <= 1'b1;
                    r_rd_lvl     <= '0;
                    r_rd_lvl_gte <= (i_rd_lvl_thr == '0);
                end else begin
                    r_cnt        <= w_nxt;
                    r_wr_rdy     <= (w_nxt != CAP_L);
                    r_rd_vld     <= (w_nxt != '0);
                    r_wr_lim     <= (w_nxt == CAP_L);
                    r_wr_lvl     <= w_free;
                    r_wr_lvl_gte <= (w_free >= i_wr_lvl_thr);
                    r_rd_lim     <= (w_nxt == '0);
                    r_rd_lvl     <= w_nxt;
                    r_rd_lvl_gte <= (w_nxt >= i_rd_lvl_thr);
                end
            end

            assign o_wr_rdy     = r_wr_rdy;
            assign o_rd_vld     = r_rd_vld;
            assign o_rd_data    = r_mem[w_top_addr];
            assign o_wr_lim     = r_wr_lim;
            assign o_wr_lvl     = r_wr_lvl;
            assign o_wr_lvl_gte = r_wr_lvl_gte;
            assign o_rd_lim     = r_rd_lim;
            assign o_rd_lvl     = r_rd_lvl;
            assign o_rd_lvl_gte = r_rd_lvl_gte;
        end
    endgenerate

endmodule

// File: tb/tb_ds_lifo.sv
// tb_ds_lifo: directed checks of the 8-entry stack and the zero-capacity bypass.
module tb_ds_lifo;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_wr_vld;
    logic       o_wr_rdy;
    logic [7:0] i_wr_data;
    logic       o_rd_vld;
    logic       i_rd_rdy;
    logic [7:0] o_rd_data;
    logic [3:0] i_wr_lvl_thr;
    logic       o_wr_lim;
    logic [3:0] o_wr_lvl;
    logic       o_wr_lvl_gte;
    logic [3:0] i_rd_lvl_thr;
    logic       o_rd_lim;
    logic [3:0] o_rd_lvl;
    logic       o_rd_lvl_gte;

    logic       b_wr_vld;
    logic       b_wr_rdy;
    logic [7:0] b_wr_data;
    logic       b_rd_vld;
    logic       b_rd_rdy;
    logic [7:0] b_rd_data;
    logic       b_wr_lim;
    logic [0:0] b_wr_lvl;
    logic       b_wr_lvl_gte;
    logic       b_rd_lim;
    logic [0:0] b_rd_lvl;
    logic       b_rd_lvl_gte;

    int n_total = 0;
    int n_bad   = 0;

    always #5 i_clk = ~i_clk;

    ds_lifo #(.CAPACITY(8), .DTYPE(logic [7:0])) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wr_vld(i_wr_vld), .o_wr_rdy(o_wr_rdy), .i_wr_data(i_wr_data),
        .o_rd_vld(o_rd_vld), .i_rd_rdy(i_rd_rdy), .o_rd_data(o_rd_data),
        .i_wr_lvl_thr(i_wr_lvl_thr), .o_wr_lim(o_wr_lim), .o_wr_lvl(o_wr_lvl),
        .o_wr_lvl_gte(o_wr_lvl_gte), .i_rd_lvl_thr(i_rd_lvl_thr), .o_rd_lim(o_rd_lim),
        .o_rd_lvl(o_rd_lvl), .o_rd_lvl_gte(o_rd_lvl_gte)
    );

    ds_lifo #(.CAPACITY(0), .DTYPE(logic [7:0])) u_byp (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wr_vld(b_wr_vld), .o_wr_rdy(b_wr_rdy), .i_wr_data(b_wr_data),
        .o_rd_vld(b_rd_vld), .i_rd_rdy(b_rd_rdy), .o_rd_data(b_rd_data),
        .i_wr_lvl_thr(1'b1), .o_wr_lim(b_wr_lim), .o_wr_lvl(b_wr_lvl),
        .o_wr_lvl_gte(b_wr_lvl_gte), .i_rd_lvl_thr(1'b1), .o_rd_lim(b_rd_lim),
        .o_rd_lvl(b_rd_lvl), .o_rd_lvl_gte(b_rd_lvl_gte)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        i_wr_vld  = 1'b1;
        i_wr_data = d;
        step();
        i_wr_vld  = 1'b0;
    endtask

    task automatic pop();
        i_rd_rdy = 1'b1;
        step();
        i_rd_rdy = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_rdy"}, o_wr_rdy, 1);
        chk({tag, "_rd_vld"}, o_rd_vld, 0);
        chk({tag, "_wr_lim"}, o_wr_lim, 0);
        chk({tag, "_wr_lvl"}, o_wr_lvl, 8);
        chk({tag, "_wr_gte"}, o_wr_lvl_gte, 1);
        chk({tag, "_rd_lim"}, o_rd_lim, 1);
        chk({tag, "_rd_lvl"}, o_rd_lvl, 0);
        chk({tag, "_rd_gte"}, o_rd_lvl_gte, 1);
    endtask

    initial begin
        i_rst = 1'b1; i_wr_vld = 1'b0; i_rd_rdy = 1'b0; i_wr_data = 8'h00;
        i_wr_lvl_thr = 4'd0; i_rd_lvl_thr = 4'd0;
        b_wr_vld = 1'b0; b_rd_rdy = 1'b0; b_wr_data = 8'h00;
        step();
        step();
        chk_reset_vals("rst");
        i_rst = 1'b0;

        // Push 1,2,3 then pop back in reverse order.
        push(8'd1);
        chk("t1_vld_after_push", o_rd_vld, 1);
        chk("t1_top1", o_rd_data, 1);
        chk("t1_lvl1", o_rd_lvl, 1);
        push(8'd2);
        push(8'd3);
        chk("t1_lvl3", o_rd_lvl, 3);
        chk("t1_wrlvl5", o_wr_lvl, 5);
        for (int k = 3; k >= 1; k--) begin
            chk("t1_pop_data", o_rd_data, k);
            pop();
            chk("t1_pop_lvl", o_rd_lvl, k - 1);
        end
        chk("t1_empty_vld", o_rd_vld, 0);
        chk("t1_empty_lim", o_rd_lim, 1);

        // Fill to capacity, hold a ninth push, pop once to let it in.
        for (int k = 0; k < 8; k++) push(8'(8'h10 + k));
        chk("t2_full_rdy", o_wr_rdy, 0);
        chk("t2_full_lim", o_wr_lim, 1);
        chk("t2_full_wrlvl", o_wr_lvl, 0);
        chk("t2_full_rdlvl", o_rd_lvl, 8);
        chk("t2_full_top", o_rd_data, 8'h17);
        i_wr_vld = 1'b1; i_wr_data = 8'h99;
        step();
        chk("t2_held_top", o_rd_data, 8'h17);
        chk("t2_held_lvl", o_rd_lvl, 8);
        i_rd_rdy = 1'b1;
        step();
        i_rd_rdy = 1'b0;
        chk("t2_rdy_back", o_wr_rdy, 1);
        chk("t2_lvl7", o_rd_lvl, 7);
        chk("t2_top16", o_rd_data, 8'h16);
        step();
        i_wr_vld = 1'b0;
        chk("t2_ninth_top", o_rd_data, 8'h99);
        chk("t2_ninth_lvl", o_rd_lvl, 8);
        for (int k = 0; k < 8; k++) pop();
        chk("t2_drained", o_rd_lim, 1);

        // Simultaneous push and pop replaces the top in place.
        push(8'hA1);
        push(8'hB2);
        i_wr_vld = 1'b1; i_wr_data = 8'hC3; i_rd_rdy = 1'b1;
        chk("t3_popped_word", o_rd_data, 8'hB2);
        step();
        i_wr_vld = 1'b0; i_rd_rdy = 1'b0;
        chk("t3_new_top", o_rd_data, 8'hC3);
        chk("t3_lvl", o_rd_lvl, 2);
        pop();
        chk("t3_under", o_rd_data, 8'hA1);
        pop();
        chk("t3_empty", o_rd_vld, 0);

        // Occupancy threshold crossing and a threshold-only change.
        i_rd_lvl_thr = 4'd4;
        i_wr_lvl_thr = 4'd5;
        step();
        chk("t4_gte_idle", o_rd_lvl_gte, 0);
        chk("t4_wgte_idle", o_wr_lvl_gte, 1);
        push(8'h41); push(8'h42); push(8'h43);
        chk("t4_gte_3", o_rd_lvl_gte, 0);
        chk("t4_wgte_3", o_wr_lvl_gte, 1);
        push(8'h44);
        chk("t4_gte_4", o_rd_lvl_gte, 1);
        chk("t4_wgte_4", o_wr_lvl_gte, 0);
        i_rd_lvl_thr = 4'd5;
        chk("t4_gte_before_edge", o_rd_lvl_gte, 1);
        step();
        chk("t4_gte_thr5", o_rd_lvl_gte, 0);
        chk("t4_lvl_kept", o_rd_lvl, 4);
        i_rd_lvl_thr = 4'd0;
        i_wr_lvl_thr = 4'd0;
        for (int k = 0; k < 4; k++) pop();

        // Reset mid-operation discards content and wins over a pending push.
        for (int k = 0; k < 5; k++) push(8'(8'h50 + k));
        chk("t5_lvl5", o_rd_lvl, 5);
        i_rst = 1'b1; i_wr_vld = 1'b1; i_wr_data = 8'hEE; i_rd_rdy = 1'b1;
        step();
        i_rst = 1'b0; i_wr_vld = 1'b0;
        chk_reset_vals("t5");
        step();
        i_rd_rdy = 1'b0;
        chk("t5_pop_empty_lvl", o_rd_lvl, 0);
        chk("t5_pop_empty_wrlvl", o_wr_lvl, 8);
        push(8'h55);
        chk("t5_push_top", o_rd_data, 8'h55);
        chk("t5_push_lvl", o_rd_lvl, 1);
        pop();
        chk("t5_final_empty", o_rd_lim, 1);

        // Zero-capacity bypass mirrors its inputs combinationally.
        for (int k = 0; k < 24; k++) begin
            b_wr_vld  = 1'($urandom_range(0, 1));
            b_rd_rdy  = 1'($urandom_range(0, 1));
            b_wr_data = 8'($urandom_range(0, 255));
            #1;
            chk("t6_rdy", b_wr_rdy, b_rd_rdy);
            chk("t6_vld", b_rd_vld, b_wr_vld);
            chk("t6_data", b_rd_data, b_wr_data);
            chk("t6_levels", {b_wr_lim, b_wr_lvl, b_wr_lvl_gte, b_rd_lim, b_rd_lvl, b_rd_lvl_gte}, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
